// File: rtl/fetch_issue_pkg.sv
// fetch_issue_pkg
// Shared definitions for the fetch/issue unit and the decoder it feeds:
//   - LEN_WORD / LEN_INST : default address width and instruction width
//   - FETCH / ISSUE / WAIT : fetch_issue state encodings
//   - WAIT_REG / WAIT_EXEC : decoder's next_pc_wait_type encodings
//   - pc_sel_t             : source selector for the next_pc_select mux
//   - cnt_width()          : width of the fetch latency counter
package fetch_issue_pkg;

    localparam int LEN_WORD = 32;
    localparam int LEN_INST = 32;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic WAIT_REG  = 1'b0;
    localparam logic WAIT_EXEC = 1'b1;

    typedef enum logic [1:0] {
        SEL_NORMAL = 2'd0,
        SEL_EXEC   = 2'd1,
        SEL_REG    = 2'd2
    } pc_sel_t;

    // The counter must hold 0..latency, so clog2(latency+1) bits, never fewer than one.
    function automatic int cnt_width(input int latency);
        int w;
        w = $clog2(latency + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fetch_issue_next_pc_select.sv
// fetch_issue_next_pc_select
// Combinational choice of the next program counter.
//   mode            : SEL_NORMAL (decoder's next_pc), SEL_EXEC (branch outcome),
//                     SEL_REG (register-computed JALR target)
//   next_pc         : live decoder next_pc, used in SEL_NORMAL
//   held_next_pc    : latched fall-through address, used in SEL_EXEC when not taken
//   held_branched   : latched taken-branch target, used in SEL_EXEC when taken
//   resolve_taken   : branch outcome from execute
//   resolve_target  : register target from execute, used in SEL_REG
//   new_pc          : selected address with bits [1:0] cleared
module fetch_issue_next_pc_select #(
    parameter int LEN_WORD = 32
) (
    input  logic [1:0]          mode,
    input  logic [LEN_WORD-1:0] next_pc,
    input  logic [LEN_WORD-1:0] held_next_pc,
    input  logic [LEN_WORD-1:0] held_branched,
    input  logic                resolve_taken,
    input  logic [LEN_WORD-1:0] resolve_target,
    output logic [LEN_WORD-1:0] new_pc
);
    import fetch_issue_pkg::*;

    logic [LEN_WORD-1:0] raw_pc;

    always_comb begin
        raw_pc = next_pc;
        case (pc_sel_t'(mode))
            SEL_NORMAL: raw_pc = next_pc;
            SEL_EXEC:   raw_pc = resolve_taken ? held_branched : held_next_pc;
            SEL_REG:    raw_pc = resolve_target;
            default:    raw_pc = next_pc;
        endcase
        // Instructions are word aligned; whatever the source, drop the byte offset.
        new_pc = raw_pc & ~LEN_WORD'(3);
    end

endmodule

// File: rtl/fetch_issue.sv
// fetch_issue
// Instruction fetch/issue unit: holds the PC, reads instruction memory with a
// fixed latency, hands one instruction at a time to the decoder and follows the
// decoder's (or the execute stage's) choice of the next PC.
//   clk, rstn          : clock, asynchronous active-low reset
//   imem_addr          : instruction memory byte address (always equal to pc)
//   imem_rdata         : instruction word, valid IMEM_LATENCY cycles after imem_addr
//   order / done       : instruction valid to decoder / decoder accepts it
//   instr / pc         : instruction and its address, stable while order is high
//   next_pc_normal     : decoder's next_pc is final
//   next_pc_wait_type  : WAIT_REG (JALR target) or WAIT_EXEC (branch outcome)
//   next_pc            : fall-through or direct target
//   next_pc_branched   : taken-branch target
//   resolve_valid      : execute stage resolves the pending transfer
//   resolve_taken      : branch outcome (WAIT_EXEC)
//   resolve_target     : computed target (WAIT_REG)
//   waiting            : unit is stalled waiting for resolution
//   issue_count        : number of instructions accepted by the decoder
module fetch_issue #(
    parameter int                  LEN_WORD     = fetch_issue_pkg::LEN_WORD,
    parameter int                  IMEM_LATENCY = 2,
    parameter logic [LEN_WORD-1:0] RESET_PC     = '0
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    output logic [LEN_WORD-1:0]                  imem_addr,
    input  logic [fetch_issue_pkg::LEN_INST-1:0] imem_rdata,
    output logic                                 order,
    input  logic                                 done,
    output logic [fetch_issue_pkg::LEN_INST-1:0] instr,
    output logic [LEN_WORD-1:0]                  pc,
    input  logic                                 next_pc_normal,
    input  logic                                 next_pc_wait_type,
    input  logic [LEN_WORD-1:0]                  next_pc,
    input  logic [LEN_WORD-1:0]                  next_pc_branched,
    input  logic                                 resolve_valid,
    input  logic                                 resolve_taken,
    input  logic [LEN_WORD-1:0]                  resolve_target,
    output logic                                 waiting,
    output logic [31:0]                          issue_count
);
    import fetch_issue_pkg::*;

    localparam int               CNT_W    = cnt_width(IMEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_LATENCY);

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic                wait_type_q;
    logic [LEN_WORD-1:0] held_next_pc;
    logic [LEN_WORD-1:0] held_branched;
    logic [1:0]          sel_mode;
    logic [LEN_WORD-1:0] new_pc;
    logic                accept;
    logic                resolve_now;

    assign order     = (state == ISSUE);
    assign waiting   = (state == WAIT);
    assign imem_addr = pc;

    // order is only ever high in ISSUE, so this also ignores done while order=0.
    assign accept      = (state == ISSUE) && done;
    assign resolve_now = (state == WAIT) && resolve_valid;

    always_comb begin
        sel_mode = SEL_NORMAL;
        if (state == WAIT) begin
            sel_mode = (wait_type_q == WAIT_EXEC) ? SEL_EXEC : SEL_REG;
        end
    end

    fetch_issue_next_pc_select #(
        .LEN_WORD(LEN_WORD)
    ) u_next_pc_select (
        .mode           (sel_mode),
        .next_pc        (next_pc),
        .held_next_pc   (held_next_pc),
        .held_branched  (held_branched),
        .resolve_taken  (resolve_taken),
        .resolve_target (resolve_target),
        .new_pc         (new_pc)
    );

    // State, latency counter and instruction register. The counter counts FETCH
    // cycles; the read data is captured at the end of the (IMEM_LATENCY+1)-th one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= FETCH;
            cnt   <= '0;
            instr <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        instr <= imem_rdata;
                        state <= ISSUE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ISSUE: begin
                    if (done) begin
                        state <= next_pc_normal ? FETCH : WAIT;
                    end
                end
                WAIT: begin
                    if (resolve_valid) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Program counter: moves only when the next address is known.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc <= RESET_PC;
        end else if ((accept && next_pc_normal) || resolve_now) begin
            pc <= new_pc;
        end
    end

    // Decoder's candidates are held here because the decoder moves on after done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_type_q   <= WAIT_REG;
            held_next_pc  <= '0;
            held_branched <= '0;
        end else if (accept && !next_pc_normal) begin
            wait_type_q   <= next_pc_wait_type;
            held_next_pc  <= next_pc;
            held_branched <= next_pc_branched;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_count <= '0;
        end else if (accept) begin
            issue_count <= issue_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_issue.sv
// tb_fetch_issue
// Directed self-checking bench for fetch_issue with IMEM_LATENCY=2.
// Memory model: a latency-deep address delay line feeding a fixed word function.
module tb_fetch_issue;
    import fetch_issue_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        order;
    logic        done;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        next_pc_normal;
    logic        next_pc_wait_type;
    logic [31:0] next_pc;
    logic [31:0] next_pc_branched;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        waiting;
    logic [31:0] issue_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = '0;

    always #5 clk = ~clk;

    fetch_issue #(
        .LEN_WORD     (32),
        .IMEM_LATENCY (LAT),
        .RESET_PC     (32'h0)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .order             (order),
        .done              (done),
        .instr             (instr),
        .pc                (pc),
        .next_pc_normal    (next_pc_normal),
        .next_pc_wait_type (next_pc_wait_type),
        .next_pc           (next_pc),
        .next_pc_branched  (next_pc_branched),
        .resolve_valid     (resolve_valid),
        .resolve_taken     (resolve_taken),
        .resolve_target    (resolve_target),
        .waiting           (waiting),
        .issue_count       (issue_count)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h00000013 ^ {a[23:0], 8'h00};
    endfunction

    logic [31:0] addr_pipe [LAT];

    always @(posedge clk) begin
        addr_pipe[0] <= imem_addr;
        for (int i = 1; i < LAT; i++) begin
            addr_pipe[i] <= addr_pipe[i-1];
        end
    end

    assign imem_rdata = memWord(addr_pipe[LAT-1]);

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_order, input logic exp_waiting,
                               input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        checkVal({tag, ".order"}, 32'(order), 32'(exp_order));
        checkVal({tag, ".waiting"}, 32'(waiting), 32'(exp_waiting));
        checkVal({tag, ".pc"}, pc, exp_pc);
        checkVal({tag, ".imem_addr"}, imem_addr, exp_pc);
        checkVal({tag, ".issue_count"}, issue_count, exp_cnt);
    endtask

    task automatic applyStimulus(input logic d, input logic normal, input logic wtype,
                                 input logic [31:0] npc, input logic [31:0] npc_br,
                                 input logic rv, input logic rtaken, input logic [31:0] rtarget);
        done              = d;
        next_pc_normal    = normal;
        next_pc_wait_type = wtype;
        next_pc           = npc;
        next_pc_branched  = npc_br;
        resolve_valid     = rv;
        resolve_taken     = rtaken;
        resolve_target    = rtarget;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Called at the negedge of the first FETCH cycle; order must rise exactly
    // LAT+1 cycles later with the instruction stored at exp_pc.
    task automatic expectIssueAfterFetch(input string tag, input logic [31:0] exp_pc);
        checkOutput({tag, ".f0"}, 1'b0, 1'b0, exp_pc, exp_count);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checkOutput({tag, ".f"}, 1'b0, 1'b0, exp_pc, exp_count);
        end
        @(negedge clk);
        checkOutput({tag, ".issue"}, 1'b1, 1'b0, exp_pc, exp_count);
        checkVal({tag, ".instr"}, instr, memWord(exp_pc));
    endtask

    // Starts at an ISSUE negedge with pc=cur_pc; branch waits three cycles
    // (with a stray done inside WAIT) before the outcome arrives.
    task automatic branchSeq(input string tag, input logic [31:0] cur_pc, input logic taken,
                             input logic [31:0] exp_target);
        applyStimulus(1'b1, 1'b0, WAIT_EXEC, 32'h10, 32'h40, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        exp_count++;
        checkOutput({tag, ".w1"}, 1'b0, 1'b1, cur_pc, exp_count);
        idleInputs();
        @(negedge clk);
        checkOutput({tag, ".w2"}, 1'b0, 1'b1, cur_pc, exp_count);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput({tag, ".w3"}, 1'b0, 1'b1, cur_pc, exp_count);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, taken, 32'h500);
        @(negedge clk);
        idleInputs();
        expectIssueAfterFetch(tag, exp_target);
    endtask

    typedef struct {
        logic        d;
        logic        normal;
        logic [31:0] npc;
        logic        exp_order;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Sequential code: done with pc+4 in each ISSUE cycle; done in FETCH is ignored.
        vecs[0]  = '{1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0,   32'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,   32'd0};
        vecs[2]  = '{1'b1, 1'b1, 32'h4,  1'b1, 32'h0, 32'h13,  32'd0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h4, 32'h13,  32'd1};
        vecs[4]  = '{1'b1, 1'b1, 32'h80, 1'b0, 32'h4, 32'h13,  32'd1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h4, 32'h13,  32'd1};
        vecs[6]  = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4, 32'h413, 32'd1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h8, 32'h413, 32'd2};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h8, 32'h413, 32'd2};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h8, 32'h413, 32'd2};
        vecs[10] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h8, 32'h813, 32'd2};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'hC, 32'h813, 32'd3};

        rstn = 1'b0;
        idleInputs();
        repeat (3) @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, 32'h0, 32'd0);
        checkVal("reset.instr", instr, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput($sformatf("seq[%0d]", i), vecs[i].exp_order, 1'b0, vecs[i].exp_pc,
                        vecs[i].exp_cnt);
            checkVal($sformatf("seq[%0d].instr", i), instr, vecs[i].exp_instr);
            applyStimulus(vecs[i].d, vecs[i].normal, 1'b0, vecs[i].npc, 32'h0, 1'b0, 1'b0, 32'h0);
        end
        exp_count = 32'd3;

        expectIssueAfterFetch("seqNext", 32'hC);
        branchSeq("brTaken", 32'hC, 1'b1, 32'h40);
        branchSeq("brNotTaken", 32'h40, 1'b0, 32'h10);

        // JALR: the resolve pulse in the done cycle must not end the wait.
        applyStimulus(1'b1, 1'b0, WAIT_REG, 32'h14, 32'h80, 1'b1, 1'b0, 32'h200);
        @(negedge clk);
        exp_count++;
        checkOutput("jalr.w1", 1'b0, 1'b1, 32'h10, exp_count);
        idleInputs();
        @(negedge clk);
        checkOutput("jalr.w2", 1'b0, 1'b1, 32'h10, exp_count);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h103);
        @(negedge clk);
        idleInputs();
        checkOutput("jalr.fetch", 1'b0, 1'b0, 32'h100, exp_count);

        // Asynchronous reset in the middle of FETCH.
        @(negedge clk);
        checkOutput("midF.pre", 1'b0, 1'b0, 32'h100, exp_count);
        #2 rstn = 1'b0;
        #1;
        exp_count = '0;
        checkOutput("midF.rst", 1'b0, 1'b0, 32'h0, exp_count);
        checkVal("midF.rst.instr", instr, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        expectIssueAfterFetch("afterF", 32'h0);

        // Asynchronous reset in the middle of WAIT.
        applyStimulus(1'b1, 1'b0, WAIT_REG, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        exp_count++;
        idleInputs();
        checkOutput("midW.pre", 1'b0, 1'b1, 32'h0, exp_count);
        #2 rstn = 1'b0;
        #1;
        exp_count = '0;
        checkOutput("midW.rst", 1'b0, 1'b0, 32'h0, exp_count);
        checkVal("midW.rst.instr", instr, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        expectIssueAfterFetch("afterW", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_issue.md
Name: fetch_issue

Overview:
- Instruction fetch/issue unit on the producer side of the decode handshake.
- Holds the architectural PC and reads instruction memory with a fixed read latency.
- Presents `instr`/`pc` to the decoder via `order`/`done`.
- Computes the following PC from the decoder's next-PC outputs. When the decoder cannot resolve the PC (branch or JALR), it stalls until the execute stage reports resolution.

Parameters:
- LEN_WORD, 32, data/address width.
- IMEM_LATENCY, 2, cycles from `imem_addr` valid to `imem_rdata` valid; legal range 1..7.
- RESET_PC, 32'h0, PC after reset.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- imem_addr  out  LEN_WORD  byte address to instruction memory
- imem_rdata  in  32  instruction word, valid IMEM_LATENCY cycles after imem_addr
- order  out  1  instr/pc valid to decoder
- done  in  1  decoder accepts instr this cycle
- instr  out  32  instruction to decoder
- pc  out  LEN_WORD  address of instr
- next_pc_normal  in  1  decoder: next_pc is final
- next_pc_wait_type  in  1  0 = wait for register (JALR target), 1 = wait for exec (branch outcome)
- next_pc  in  LEN_WORD  fall-through or direct target
- next_pc_branched  in  LEN_WORD  taken-branch target
- resolve_valid  in  1  exec stage resolves pending control transfer
- resolve_taken  in  1  branch taken (wait_type=1 only)
- resolve_target  in  LEN_WORD  computed target (wait_type=0 only)
- waiting  out  1  high in WAIT state
- issue_count  out  32  number of accepted instructions

Behaviour:
- Reset (async, rstn=0): state=FETCH, pc=RESET_PC, latency counter=0, order=0, instr=0, waiting=0, issue_count=0, imem_addr=RESET_PC. Reset mid-operation discards any pending fetch or wait.
- imem_addr is always pc.
- FETCH:
  - Counter increments each cycle.
  - At the edge ending the (IMEM_LATENCY+1)-th FETCH cycle, imem_rdata is registered into instr and state becomes ISSUE.
  - So order rises IMEM_LATENCY+1 cycles after entering FETCH.
- ISSUE:
  - order=1; instr and pc are held stable until done.
  - done=1 and next_pc_normal=1: pc <= next_pc, go to FETCH.
  - done=1 and next_pc_normal=0: latch wait_type, next_pc and next_pc_branched; go to WAIT.
  - In all done cases: order deasserts next cycle and issue_count increments, wrapping at 2^32.
- WAIT:
  - waiting=1; order=0.
  - On resolve_valid:
    - wait_type=1: pc <= resolve_taken ? latched next_pc_branched : latched next_pc.
    - wait_type=0: pc <= resolve_target.
  - Then go to FETCH.
- PC alignment: bits [1:0] of every new pc are forced to 0.
- Ignored inputs:
  - done outside ISSUE, and while order=0.
  - resolve_valid outside WAIT, including the same cycle done enters WAIT. Resolution is sampled only from the first WAIT cycle onward.
- done in the first ISSUE cycle is legal, giving zero-cycle acceptance.
- No buffering: at most one instruction is in flight. Throughput is one instruction per IMEM_LATENCY+2 cycles on sequential code.
- Counter width is clog2(IMEM_LATENCY+1) bits, minimum 1.

Decomposition:
- Shared package/include:
  - LEN_WORD and LEN_INST.
  - State encodings FETCH=2'd0, ISSUE=2'd1, WAIT=2'd2.
  - WAIT_REG=1'b0 and WAIT_EXEC=1'b1 constants, shared with the decoder.
- Sub-module next_pc_select (combinational) chooses the new pc from the mode (normal / branch / register) and the latched values. Everything else stays in one always block per register group.

Test Plan:
- Reset, IMEM_LATENCY=2, memory returns 32'h00000013 at 0 → order rises in cycle 3 after rstn release with pc=0, instr=32'h13.
- Sequential: decoder answers done=1, next_pc_normal=1, next_pc=pc+4 immediately → pc steps 0,4,8; each issue is 4 cycles apart; issue_count=3 after the third done.
- Branch taken: done with normal=0, wait_type=1, next_pc=0x10, branched=0x40; resolve_valid=1, taken=1 three cycles later → waiting=1 for those cycles, then imem_addr=0x40.
- Branch not taken: same as above with taken=0 → imem_addr=0x10.
- JALR: wait_type=0, resolve_target=0x103 → pc=0x100 (alignment enforced). A resolve_valid pulse in the done cycle itself must be ignored; the unit still waits for the next pulse.
- Async reset asserted mid-WAIT and mid-FETCH → order=0, waiting=0, pc=RESET_PC immediately without a clock edge. issue_count=0.
